breadboard_sweeper: RTL and testbench
=====================================

# breadboard_sweeper

Sequencer that runs the four-input `Breadboard` logic block through all 16 input combinations (w,x,y,z = 0000…1111). For each row it drives the inputs, waits a programmable settle time and samples r1..r3. It then emits each row over a valid/ready stream to a logger and accumulates a full 48-bit result table plus per-output ones counts. It sits between a top-level test controller (start/abort/done) and one `Breadboard` instance, and replaces delay-based sweeping with a clocked, handshaked sweep.

## Interface
- `SETTLE_CYCLES`, default 4: cycles held in SETTLE per row; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled in IDLE only.
- `abort` in 1: cancels a sweep in progress.
- `bb_w`, `bb_x`, `bb_y`, `bb_z` out 1 each: Breadboard inputs. w is row bit 3 and z is row bit 0.
- `bb_r` in 3: Breadboard outputs, packed as {r3,r2,r1}.
- `row_valid` out 1: row result available.
- `row_ready` in 1: consumer accepts the row.
- `row_idx` out 4: index of the emitted row.
- `row_data` out 3: sampled {r3,r2,r1} for `row_idx`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a sweep completes.
- `table_out` out 48: bits [3i+2:3i] hold row i's {r3,r2,r1}.
- `ones_cnt` out 15: three 5-bit counts of rows with output = 1, packed as {r3 count, r2 count, r1 count}.

## Operation
- States: IDLE, SETTLE, SAMPLE, EMIT, DONE.
- Row counter is 5 bits wide so it can represent 16. Settle counter is 8 bits.
- IDLE:
  - On `start`=1: row←0, settle count←SETTLE_CYCLES−1, clear `table_out` and `ones_cnt`, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - `bb_*` drive row[3:0], registered.
  - Count decrements each cycle. When it reaches 0, go to SAMPLE.
- SAMPLE:
  - `row_data`←`bb_r` and `row_idx`←row.
  - Write the row's slot in `table_out`.
  - Each `ones_cnt` field increments by the corresponding `bb_r` bit.
  - Go to EMIT.
- EMIT:
  - `row_valid`=1. `row_data` and `row_idx` hold stable until the handshake.
  - On `row_valid`&`row_ready`:
    - If row=15, go to DONE.
    - Otherwise row←row+1, reload the settle count and go to SETTLE.
  - `row_ready` high on the cycle valid first rises counts as a handshake.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE and `row_valid` drops.
  - No `done` pulse is produced.
  - `table_out` and `ones_cnt` keep their partial values.
  - `bb_*` return to 0.
  - `abort` takes priority over a handshake in the same cycle.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- `bb_*` are 0 whenever the block is in IDLE.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE
  - `bb_*`=0, `row_valid`=0, `row_idx`=0, `row_data`=0
  - `busy`=0, `done`=0
  - `table_out`=0, `ones_cnt`=0
- Reset mid-sweep has the same effect at any point. Release is synchronous to `clk`.
- With S = SETTLE_CYCLES and `start` sampled at edge k:
  - After edge k: `busy`=1 and the row 0 pattern is on `bb_*`.
  - First `row_valid`=1 after edge k+S+1.
  - Each row takes S+2 edges when `row_ready` is held high; each cycle of `row_ready`=0 in EMIT adds one edge.
  - `done`=1 after edge k+16(S+2). `busy` and `done` fall after the next edge.
- `bb_*` change only on the edge entering SETTLE, so the Breadboard has at least S full cycles to settle before SAMPLE.
- Final table and counts are valid and stable from the `done` cycle until the next accepted `start`.

## Test plan
- Correct Breadboard, S=4, `row_ready`=1, pulse `start`:
  - 16 rows emitted in index order 0..15.
  - `done` occurs 96 cycles after `start`.
  - `ones_cnt` = {5'd2, 5'd10, 5'd10}.
  - r1=r2=1 exactly on rows 1,4,5,6,7,9,12,13,14,15. r3=1 only on rows 0 and 15.
  - Row 0 `row_data`=3'b100, row 15 = 3'b111.
- Backpressure: hold `row_ready`=0 for 5 cycles on row 3.
  - `row_valid`, `row_idx`=3 and `row_data`=3'b000 stay stable.
  - `bb_*` do not advance.
  - `done` arrives 5 cycles later than in the baseline.
- Abort during row 7 SETTLE:
  - IDLE on the next cycle, no `done`, `bb_*`=0.
  - `table_out` rows 0..6 filled and rows 7..15 = 0. `ones_cnt` reflects rows 0..6 only.
- Pulse `start` mid-sweep: ignored, sweep unaffected.
- Pulse `start` after `done`: table and counts clear, and a full sweep repeats with identical results.
- Async reset asserted mid-EMIT between clock edges: all outputs go to their reset values immediately. Repeat with S=1: per-row period is 3 cycles, `done` occurs 48 cycles after `start`.

Source files
------------

// File: rtl/breadboard_sweeper.sv
// Clocked sweep of a four-input Breadboard block through all 16 input rows.
// Each row is driven, settled, sampled, streamed out and folded into a result table.
module breadboard_sweeper #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        bb_w,
  output logic        bb_x,
  output logic        bb_y,
  output logic        bb_z,
  input  logic [2:0]  bb_r,
  output logic        row_valid,
  input  logic        row_ready,
  output logic [3:0]  row_idx,
  output logic [2:0]  row_data,
  output logic        busy,
  output logic        done,
  output logic [47:0] table_out,
  output logic [14:0] ones_cnt
);

  // Stream handshake: row_idx/row_data are held stable while row_valid is high;
  // a row transfers on any rising clk edge with row_valid && row_ready (and no abort).

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [4:0]  row;
  logic [7:0]  settle_cnt;
  logic [3:0]  pattern;
  logic        launch;
  logic        handshake;
  logic        last_row;
  logic [5:0]  slot;

  assign launch    = (state == IDLE) && start && !abort;
  assign handshake = (state == EMIT) && row_ready && !abort;
  assign last_row  = (row == 5'd15);
  assign slot      = 6'(row[3:0]) * 6'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = SETTLE;
      SETTLE:  if (settle_cnt == 8'd0) next_state = SAMPLE;
      SAMPLE:  next_state = EMIT;
      EMIT:    if (handshake) next_state = last_row ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // abort overrides every transition, including a same-cycle handshake
    if (abort && (state != IDLE)) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= 5'd0;
      settle_cnt <= 8'd0;
      pattern    <= 4'd0;
      row_idx    <= 4'd0;
      row_data   <= 3'd0;
      table_out  <= 48'd0;
      ones_cnt   <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            row        <= 5'd0;
            settle_cnt <= SETTLE_INIT;
            pattern    <= 4'd0;
            table_out  <= 48'd0;
            ones_cnt   <= 15'd0;
          end
        end
        SETTLE: begin
          if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        end
        SAMPLE: begin
          // an aborted row is left out of the table and counts
          if (!abort) begin
            row_data             <= bb_r;
            row_idx              <= row[3:0];
            table_out[slot +: 3] <= bb_r;
            ones_cnt[4:0]        <= ones_cnt[4:0]   + 5'(bb_r[0]);
            ones_cnt[9:5]        <= ones_cnt[9:5]   + 5'(bb_r[1]);
            ones_cnt[14:10]      <= ones_cnt[14:10] + 5'(bb_r[2]);
          end
        end
        EMIT: begin
          if (handshake && !last_row) begin
            row        <= row + 5'd1;
            settle_cnt <= SETTLE_INIT;
            pattern    <= row[3:0] + 4'd1;
          end
        end
        default: ;
      endcase
      // inputs to the Breadboard rest at zero whenever the sweeper is idle
      if (next_state == IDLE) pattern <= 4'd0;
    end
  end

  assign {bb_w, bb_x, bb_y, bb_z} = pattern;
  assign row_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Bench for breadboard_sweeper: two instances (settle 4 and settle 1) driven by
// directed and randomized sweeps, checked cycle by cycle against a row-timing model.
module tb_breadboard_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start_v   [2];
  logic        abort_v   [2];
  logic        ready_v   [2];
  logic        bb_w_v    [2];
  logic        bb_x_v    [2];
  logic        bb_y_v    [2];
  logic        bb_z_v    [2];
  logic [2:0]  bb_r_v    [2];
  logic        valid_v   [2];
  logic [3:0]  idx_v     [2];
  logic [2:0]  data_v    [2];
  logic        busy_v    [2];
  logic        done_v    [2];
  logic [47:0] table_v   [2];
  logic [14:0] ones_v    [2];
  logic [3:0]  pat_v     [2];
  logic [47:0] truth_v   [2];

  int          cyc;
  int          n_checks;
  int          n_errors;
  bit          rdy_pat   [1024];
  bit          start_pat [1024];
  logic [6:0]  exp_q [$];

  breadboard_sweeper #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .bb_w(bb_w_v[0]), .bb_x(bb_x_v[0]), .bb_y(bb_y_v[0]), .bb_z(bb_z_v[0]),
    .bb_r(bb_r_v[0]), .row_valid(valid_v[0]), .row_ready(ready_v[0]),
    .row_idx(idx_v[0]), .row_data(data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .table_out(table_v[0]), .ones_cnt(ones_v[0])
  );

  breadboard_sweeper #(.SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .bb_w(bb_w_v[1]), .bb_x(bb_x_v[1]), .bb_y(bb_y_v[1]), .bb_z(bb_z_v[1]),
    .bb_r(bb_r_v[1]), .row_valid(valid_v[1]), .row_ready(ready_v[1]),
    .row_idx(idx_v[1]), .row_data(data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .table_out(table_v[1]), .ones_cnt(ones_v[1])
  );

  // Breadboard stand-ins: each is a lookup into its truth table
  assign pat_v[0]  = {bb_w_v[0], bb_x_v[0], bb_y_v[0], bb_z_v[0]};
  assign pat_v[1]  = {bb_w_v[1], bb_x_v[1], bb_y_v[1], bb_z_v[1]};
  assign bb_r_v[0] = truth_v[0][int'(pat_v[0]) * 3 +: 3];
  assign bb_r_v[1] = truth_v[1][int'(pat_v[1]) * 3 +: 3];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] canon_truth();
    logic [47:0] t;
    logic        r12;
    logic        r3;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      r12 = (i inside {1, 4, 5, 6, 7, 9, 12, 13, 14, 15});
      r3  = (i == 0) || (i == 15);
      t[i*3 +: 3] = {r3, r12, r12};
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic rd, input logic ab);
    start_v[sel] = st;
    ready_v[sel] = rd;
    abort_v[sel] = ab;
  endtask

  task automatic chk_reset_outputs(input int sel, input string tag);
    chk({tag, "_bb"},    64'(pat_v[sel]),   64'd0);
    chk({tag, "_valid"}, 64'(valid_v[sel]), 64'd0);
    chk({tag, "_idx"},   64'(idx_v[sel]),   64'd0);
    chk({tag, "_data"},  64'(data_v[sel]),  64'd0);
    chk({tag, "_busy"},  64'(busy_v[sel]),  64'd0);
    chk({tag, "_done"},  64'(done_v[sel]),  64'd0);
    chk({tag, "_table"}, 64'(table_v[sel]), 64'd0);
    chk({tag, "_ones"},  64'(ones_v[sel]),  64'd0);
  endtask

  // One sweep on instance sel. Row i's window (offsets from the start edge):
  // inputs applied from pv[i], sampled at edge eb[i]=pv[i]+S+1, transferred at
  // the first edge e[i]>eb[i] where ready is high; row i+1 begins at e[i].
  task automatic run_sweep(input int sel, input int abort_row, input int abort_ph, input string tag);
    int          s;
    int          pv [16];
    int          eb [16];
    int          e  [16];
    int          t;
    int          abort_at;
    int          end_off;
    int          row_in;
    int          vrow;
    bit          active;
    logic [47:0] exp_tab;
    int          cnt [3];
    logic [2:0]  rd;
    logic [6:0]  got;
    logic [6:0]  want;

    s = (sel == 1) ? 1 : 4;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      pv[i] = t;
      eb[i] = t + s + 1;
      t = eb[i] + 1;
      while (!rdy_pat[t] && t < 1000) t++;
      e[i] = t;
    end
    abort_at = (abort_row >= 0) ? pv[abort_row] + abort_ph : -1;
    if (abort_at > e[15]) abort_at = -1;
    end_off = (abort_at >= 0) ? abort_at : e[15];
    for (int j = end_off; j < 1024; j++) start_pat[j] = 1'b0;

    exp_tab = '0;
    cnt = '{0, 0, 0};
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      rd = truth_v[sel][i*3 +: 3];
      if (abort_at < 0 || eb[i] < abort_at) begin
        exp_tab[i*3 +: 3] = rd;
        for (int b = 0; b < 3; b++) cnt[b] += int'(rd[b]);
      end
      if (abort_at < 0 || e[i] < abort_at) exp_q.push_back({4'(i), rd});
    end

    @(posedge clk); #1;
    drive(sel, 1'b1, rdy_pat[0], 1'b0);
    @(posedge clk); #1;
    for (int off = 0; off <= end_off + 3; off++) begin
      drive(sel, start_pat[off+1], rdy_pat[off+1], (off + 1 == abort_at));
      @(negedge clk);
      active = (abort_at < 0) || (off < abort_at);
      row_in = -1;
      vrow   = -1;
      for (int i = 0; i < 16; i++) begin
        if (pv[i] <= off && off < e[i]) row_in = i;
        if (eb[i] <= off && off < e[i]) vrow = i;
      end
      if (off == 0) begin
        chk({tag, "_clr_table"}, 64'(table_v[sel]), 64'd0);
        chk({tag, "_clr_ones"},  64'(ones_v[sel]),  64'd0);
      end
      chk({tag, "_busy"},  64'(busy_v[sel]),  64'(active && off <= e[15]));
      chk({tag, "_done"},  64'(done_v[sel]),  64'(active && off == e[15]));
      chk({tag, "_valid"}, 64'(valid_v[sel]), 64'(active && vrow >= 0));
      chk({tag, "_bb"},    64'(pat_v[sel]),
          !active ? 64'd0 : (row_in >= 0) ? 64'(row_in) : (off == e[15]) ? 64'd15 : 64'd0);
      if (active && vrow >= 0) begin
        chk({tag, "_idx"},  64'(idx_v[sel]),  64'(vrow));
        chk({tag, "_data"}, 64'(data_v[sel]), 64'(truth_v[sel][vrow*3 +: 3]));
      end
      // scoreboard: every transfer must match the next expected row, at its edge
      if (valid_v[sel] && ready_v[sel] && !abort_v[sel]) begin
        got = {idx_v[sel], data_v[sel]};
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_row"}, 64'(got), 64'h80);
        end else begin
          want = exp_q.pop_front();
          chk({tag, "_row"},     64'(got),     64'(want));
          chk({tag, "_hs_edge"}, 64'(off + 1), 64'(e[want[6:3]]));
        end
      end
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
    chk({tag, "_rows_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_table"},     64'(table_v[sel]), 64'(exp_tab));
    chk({tag, "_ones"},      64'(ones_v[sel]),  64'({5'(cnt[2]), 5'(cnt[1]), 5'(cnt[0])}));
  endtask

  task automatic fill_patterns(input int ready_pct, input int start_pct);
    for (int j = 0; j < 1024; j++) begin
      rdy_pat[j]   = ($urandom_range(99, 0) < ready_pct);
      start_pat[j] = ($urandom_range(99, 0) < start_pct);
    end
  endtask

  initial begin
    logic [63:0] rnd;
    bit          seen;
    cyc      = 0;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0);
      truth_v[d] = canon_truth();
    end

    repeat (3) @(negedge clk);
    chk_reset_outputs(0, "reset");
    chk("reset_fast_busy", 64'(busy_v[1]), 64'd0);
    #1 rst_n = 1'b1;

    // start and abort together while idle: abort wins
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("start_abort_busy", 64'(busy_v[0]), 64'd0);
    chk("start_abort_bb",   64'(pat_v[0]),  64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0);

    // baseline: ready held high, done 96 edges after start
    fill_patterns(100, 0);
    run_sweep(0, -1, 0, "base");
    chk("base_ones_const", 64'(ones_v[0]), 64'({5'd2, 5'd10, 5'd10}));
    chk("base_row0",       64'(table_v[0][2:0]),   64'(3'b100));
    chk("base_row15",      64'(table_v[0][47:45]), 64'(3'b111));

    // backpressure on row 3 for 5 cycles; restart after done repeats the table
    fill_patterns(100, 0);
    for (int j = 24; j <= 28; j++) rdy_pat[j] = 1'b0;
    run_sweep(0, -1, 0, "bp");

    // start pulses while busy are ignored
    fill_patterns(100, 40);
    run_sweep(0, -1, 0, "midstart");

    // abort during row 7 settle
    fill_patterns(100, 0);
    run_sweep(0, 7, 1, "abort7");
    repeat (4) begin
      @(negedge clk);
      chk("abort7_no_done", 64'(done_v[0]), 64'd0);
    end

    // randomized tables, backpressure, stray starts and occasional aborts
    for (int it = 0; it < 6; it++) begin
      int sel;
      sel = it % 2;
      rnd = {$urandom(), $urandom()};
      truth_v[sel] = rnd[47:0];
      fill_patterns($urandom_range(90, 30), $urandom_range(20, 0));
      if ($urandom_range(2, 0) == 0)
        run_sweep(sel, $urandom_range(15, 0), $urandom_range(6, 1), "rand_abort");
      else
        run_sweep(sel, -1, 0, "rand");
    end

    // asynchronous reset between edges while a row is on offer
    truth_v[0] = canon_truth();
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = valid_v[0];
    end
    chk("rst_emit_reached", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(0, "async_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy_v[0]), 64'd0);

    // settle time 1: rows every 3 edges, done 48 edges after start
    truth_v[1] = canon_truth();
    fill_patterns(100, 0);
    run_sweep(1, -1, 0, "fast");
    chk("fast_ones_const", 64'(ones_v[1]), 64'({5'd2, 5'd10, 5'd10}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
